// File: rtl/jtag_gpio_pkg.sv
`timescale 1ns/1ps
// jtag_gpio_pkg: virtual-IR opcodes, DR lengths and decode helpers for the JTAG GPIO controller.
package jtag_gpio_pkg;

  localparam logic [3:0] IR_IDCODE      = 4'h0;
  localparam logic [3:0] IR_GPIO_CONFIG = 4'h2;
  localparam logic [3:0] IR_GPIO_DATA   = 4'h3;
  localparam logic [3:0] IR_GPIO_SET    = 4'h4;
  localparam logic [3:0] IR_GPIO_CLR    = 4'h5;
  localparam logic [3:0] IR_STATUS      = 4'h6;
  localparam logic [3:0] IR_BYPASS      = 4'hF;

  localparam int STATUS_LEN = 8;
  localparam int IDCODE_LEN = 32;
  localparam int CNT_MAX    = 127;

  typedef enum logic [2:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_CONFIG,
    DR_DATA,
    DR_SET,
    DR_CLR,
    DR_STATUS
  } dr_sel_t;

  // Unlisted opcodes fall back to the 1-bit bypass register.
  function automatic dr_sel_t decode_ir(input logic [31:0] op);
    dr_sel_t sel;
    case (op)
      32'(IR_IDCODE):      sel = DR_IDCODE;
      32'(IR_GPIO_CONFIG): sel = DR_CONFIG;
      32'(IR_GPIO_DATA):   sel = DR_DATA;
      32'(IR_GPIO_SET):    sel = DR_SET;
      32'(IR_GPIO_CLR):    sel = DR_CLR;
      32'(IR_STATUS):      sel = DR_STATUS;
      default:             sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

  function automatic logic [6:0] dr_len(input logic [31:0] op, input int nr_gpios);
    logic [6:0] len;
    case (decode_ir(op))
      DR_IDCODE:                          len = 7'(IDCODE_LEN);
      DR_CONFIG, DR_DATA, DR_SET, DR_CLR: len = 7'(nr_gpios);
      DR_STATUS:                          len = 7'(STATUS_LEN);
      default:                            len = 7'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/jtag_gpio_sync.sv
`timescale 1ns/1ps
// jtag_gpio_sync: parameterised-width 2-flop synchronizer with asynchronous active-high reset.
module jtag_gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jtag_gpio_ctrl.sv
`timescale 1ns/1ps
// jtag_gpio_ctrl: TCK-domain virtual-JTAG DR owner driving GPIO value/enable registers.
// Define JTAG_GPIO_SYNC_EN to pass gpio_in through a 2-flop synchronizer before capture.
module jtag_gpio_ctrl #(
  parameter int          IR_BITS  = 4,
  parameter int          NR_GPIOS = 8,
  parameter logic [31:0] IDCODE   = 32'h149511C3
) (
  input  logic                tck,
  input  logic                reset,
  input  logic [IR_BITS-1:0]  ir,
  input  logic                capture_dr,
  input  logic                shift_dr,
  input  logic                update_dr,
  input  logic                tdi,
  output logic                tdo,
  input  logic [NR_GPIOS-1:0] gpio_in,
  output logic [NR_GPIOS-1:0] gpio_out,
  output logic [NR_GPIOS-1:0] gpio_oe,
  output logic                length_err
);

  import jtag_gpio_pkg::*;

  logic [IR_BITS-1:0]  ir_q;
  logic [31:0]         dr;
  logic [31:0]         dr_shifted;
  logic [31:0]         cap_val;
  logic [6:0]          bit_cnt;
  logic [6:0]          last_len;
  logic [6:0]          len_q;
  logic [4:0]          msb_pos;
  logic [NR_GPIOS-1:0] gpio_cap;
  logic [NR_GPIOS-1:0] dr_word;
  dr_sel_t             sel_cap;
  dr_sel_t             sel_q;
  logic                writable;

`ifdef JTAG_GPIO_SYNC_EN
  jtag_gpio_sync #(.WIDTH(NR_GPIOS)) u_sync (
    .clk   (tck),
    .reset (reset),
    .d     (gpio_in),
    .q     (gpio_cap)
  );
`else
  assign gpio_cap = gpio_in;
`endif

  // Capture decodes the live IR; shift and update use the IR latched at capture.
  assign sel_cap  = decode_ir(32'(ir));
  assign sel_q    = decode_ir(32'(ir_q));
  assign len_q    = dr_len(32'(ir_q), NR_GPIOS);
  assign msb_pos  = 5'(len_q - 7'd1);
  assign dr_word  = dr[NR_GPIOS-1:0];
  assign writable = (sel_q != DR_IDCODE) && (sel_q != DR_BYPASS);
  assign tdo      = dr[0];

  always_comb begin
    cap_val = '0;
    case (sel_cap)
      DR_IDCODE:      cap_val = IDCODE;
      DR_CONFIG:      cap_val = 32'(gpio_oe);
      DR_DATA:        cap_val = 32'(gpio_cap);
      DR_SET, DR_CLR: cap_val = 32'(gpio_out);
      DR_STATUS:      cap_val = 32'({last_len, length_err});
      default:        cap_val = '0;
    endcase
  end

  // tdi enters at the top of the selected DR, which may be shorter than the 32-bit register.
  always_comb begin
    dr_shifted          = dr >> 1;
    dr_shifted[msb_pos] = tdi;
  end

  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      ir_q       <= IR_BITS'(IR_BYPASS);
      dr         <= '0;
      bit_cnt    <= '0;
      last_len   <= '0;
      gpio_out   <= '0;
      gpio_oe    <= '0;
      length_err <= 1'b0;
    end else if (capture_dr) begin
      ir_q    <= ir;
      bit_cnt <= '0;
      dr      <= cap_val;
    end else if (shift_dr) begin
      dr <= dr_shifted;
      if (bit_cnt != 7'(CNT_MAX)) begin
        bit_cnt <= bit_cnt + 7'd1;
      end
    end else if (update_dr) begin
      last_len <= bit_cnt;
      // A write applies only when exactly the DR length was shifted in.
      if (writable) begin
        if (bit_cnt == len_q) begin
          case (sel_q)
            DR_CONFIG: gpio_oe  <= dr_word;
            DR_DATA:   gpio_out <= dr_word;
            DR_SET:    gpio_out <= gpio_out | dr_word;
            DR_CLR:    gpio_out <= gpio_out & ~dr_word;
            DR_STATUS: if (dr[0]) length_err <= 1'b0;
            default:   ;
          endcase
        end else begin
          length_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_gpio_ctrl.sv
`timescale 1ns/1ps
// tb_jtag_gpio_ctrl: directed and randomized DR scans checked against a scan-level reference model.
module tb_jtag_gpio_ctrl;

  localparam logic [31:0] IDCODE_VAL = 32'h149511C3;

  logic       tck = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ir = 4'h0;
  logic       capture_dr = 1'b0;
  logic       shift_dr = 1'b0;
  logic       update_dr = 1'b0;
  logic       tdi = 1'b0;
  logic       tdo;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic       length_err;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents as seen at the scan level.
  logic [7:0] m_out;
  logic [7:0] m_oe;
  logic       m_err;
  int         m_last;

  always #5 tck = ~tck;

  jtag_gpio_ctrl #(
    .IR_BITS  (4),
    .NR_GPIOS (8),
    .IDCODE   (IDCODE_VAL)
  ) dut (
    .tck        (tck),
    .reset      (reset),
    .ir         (ir),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .tdi        (tdi),
    .tdo        (tdo),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oe    (gpio_oe),
    .length_err (length_err)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic scan(input logic [3:0] op, input int n, input logic [159:0] data,
                      output logic [159:0] got);
    got = '0;
    @(negedge tck);
    ir = op;
    capture_dr = 1'b1;
    @(negedge tck);
    capture_dr = 1'b0;
    for (int i = 0; i < n; i++) begin
      shift_dr = 1'b1;
      tdi = data[i];
      got[i] = tdo;
      @(negedge tck);
    end
    shift_dr = 1'b0;
    update_dr = 1'b1;
    @(negedge tck);
    update_dr = 1'b0;
  endtask

  task automatic model_reset();
    m_out = '0;
    m_oe = '0;
    m_err = 1'b0;
    m_last = 0;
  endtask

  // Expected tdo stream: captured value first, then tdi bits delayed by the DR length.
  task automatic model_scan(input logic [3:0] op, input int n, input logic [159:0] data,
                            output logic [159:0] exp);
    logic [31:0] cap;
    logic [6:0]  last7;
    int          len;
    last7 = 7'(m_last);
    case (op)
      4'h0:       begin cap = IDCODE_VAL;               len = 32; end
      4'h2:       begin cap = {24'b0, m_oe};            len = 8;  end
      4'h3:       begin cap = {24'b0, gpio_in};         len = 8;  end
      4'h4, 4'h5: begin cap = {24'b0, m_out};           len = 8;  end
      4'h6:       begin cap = {24'b0, last7, m_err};    len = 8;  end
      default:    begin cap = 32'h0;                    len = 1;  end
    endcase
    exp = '0;
    for (int i = 0; i < n; i++) begin
      exp[i] = (i < len) ? cap[i] : data[i - len];
    end
    if (op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6}) begin
      if (n == len) begin
        case (op)
          4'h2: m_oe = data[7:0];
          4'h3: m_out = data[7:0];
          4'h4: m_out = m_out | data[7:0];
          4'h5: m_out = m_out & ~data[7:0];
          default: if (data[0]) m_err = 1'b0;
        endcase
      end else begin
        m_err = 1'b1;
      end
    end
    m_last = (n > 127) ? 127 : n;
  endtask

  task automatic test_reset();
    @(negedge tck);
    reset = 1'b1;
    #1;
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_gpio_out got=%h exp=00", gpio_out); end
    checks++; if (gpio_oe !== 8'h00) begin errors++; $display("[TB] FAIL reset_gpio_oe got=%h exp=00", gpio_oe); end
    checks++; if (length_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_length_err got=%b exp=0", length_err); end
    checks++; if (tdo !== 1'b0) begin errors++; $display("[TB] FAIL reset_tdo got=%b exp=0", tdo); end
    repeat (2) @(negedge tck);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idcode();
    logic [159:0] got, exp;
    logic [159:0] data;
    data = {$urandom, $urandom, $urandom, $urandom, $urandom};
    scan(4'h0, 32, data, got);
    model_scan(4'h0, 32, data, exp);
    checks++; if (got[31:0] !== 32'h149511C3) begin errors++; $display("[TB] FAIL idcode_stream got=%h exp=149511c3", got[31:0]); end
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL idcode_model got=%h exp=%h", got, exp); end
    checks++; if (gpio_out !== 8'h00 || gpio_oe !== 8'h00) begin errors++; $display("[TB] FAIL idcode_no_write got=%h/%h exp=00/00", gpio_out, gpio_oe); end
  endtask

  task automatic test_gpio_write();
    logic [159:0] got, exp;
    scan(4'h2, 8, 160'hA5, got);
    model_scan(4'h2, 8, 160'hA5, exp);
    checks++; if (gpio_oe !== 8'hA5) begin errors++; $display("[TB] FAIL config_write got=%h exp=a5", gpio_oe); end
    scan(4'h3, 8, 160'h3C, got);
    model_scan(4'h3, 8, 160'h3C, exp);
    checks++; if (gpio_out !== 8'h3C) begin errors++; $display("[TB] FAIL data_write got=%h exp=3c", gpio_out); end
    checks++; if (length_err !== 1'b0) begin errors++; $display("[TB] FAIL data_write_err got=%b exp=0", length_err); end
  endtask

  task automatic test_set_clr();
    logic [159:0] got, exp;
    scan(4'h4, 8, 160'h03, got);
    model_scan(4'h4, 8, 160'h03, exp);
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL set_capture got=%h exp=%h", got, exp); end
    checks++; if (gpio_out !== 8'h3F) begin errors++; $display("[TB] FAIL set_write got=%h exp=3f", gpio_out); end
    scan(4'h5, 8, 160'h0C, got);
    model_scan(4'h5, 8, 160'h0C, exp);
    checks++; if (gpio_out !== 8'h33) begin errors++; $display("[TB] FAIL clr_write got=%h exp=33", gpio_out); end
  endtask

  task automatic test_length_err();
    logic [159:0] got, exp;
    scan(4'h3, 7, 160'h7F, got);
    model_scan(4'h3, 7, 160'h7F, exp);
    checks++; if (gpio_out !== 8'h33) begin errors++; $display("[TB] FAIL short_no_write got=%h exp=33", gpio_out); end
    checks++; if (length_err !== 1'b1) begin errors++; $display("[TB] FAIL short_sets_err got=%b exp=1", length_err); end
    scan(4'h6, 8, 160'h00, got);
    model_scan(4'h6, 8, 160'h00, exp);
    checks++; if (got[7:0] !== 8'h0F) begin errors++; $display("[TB] FAIL status_read got=%h exp=0f", got[7:0]); end
    checks++; if (length_err !== 1'b1) begin errors++; $display("[TB] FAIL status_zero_keeps got=%b exp=1", length_err); end
    scan(4'h6, 8, 160'h01, got);
    model_scan(4'h6, 8, 160'h01, exp);
    checks++; if (length_err !== 1'b0) begin errors++; $display("[TB] FAIL status_clear got=%b exp=0", length_err); end
  endtask

  task automatic test_gpio_in();
    logic [159:0] got, exp;
    gpio_in = 8'h5A;
    repeat (2) @(negedge tck);
    scan(4'h3, 8, 160'h5A, got);
    model_scan(4'h3, 8, 160'h5A, exp);
    checks++; if (got[7:0] !== 8'h5A) begin errors++; $display("[TB] FAIL gpio_in_capture got=%h exp=5a", got[7:0]); end
    // Pin change one tck edge before capture.
    gpio_in = 8'h11;
    repeat (3) @(negedge tck);
    gpio_in = 8'hEE;
    scan(4'h3, 8, 160'h5A, got);
    model_scan(4'h3, 8, 160'h5A, exp);
`ifdef JTAG_GPIO_SYNC_EN
    checks++; if (got[7:0] !== 8'h11) begin errors++; $display("[TB] FAIL sync_lag got=%h exp=11", got[7:0]); end
`else
    checks++; if (got[7:0] !== 8'hEE) begin errors++; $display("[TB] FAIL direct_sample got=%h exp=ee", got[7:0]); end
`endif
  endtask

  task automatic test_saturation();
    logic [159:0] got, exp, data;
    data = {$urandom, $urandom, $urandom, $urandom, $urandom};
    scan(4'hF, 130, data, got);
    model_scan(4'hF, 130, data, exp);
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL bypass_stream got=%h exp=%h", got, exp); end
    checks++; if (length_err !== 1'b0) begin errors++; $display("[TB] FAIL bypass_no_err got=%b exp=0", length_err); end
    scan(4'h6, 8, 160'h00, got);
    model_scan(4'h6, 8, 160'h00, exp);
    checks++; if (got[7:1] !== 7'd127) begin errors++; $display("[TB] FAIL count_saturate got=%0d exp=127", got[7:1]); end
  endtask

  task automatic test_random();
    logic [159:0] got, exp, data;
    logic [3:0]   ops [9];
    logic [3:0]   op;
    int           n;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'hF};
    for (int k = 0; k < 40; k++) begin
      gpio_in = 8'($urandom);
      repeat (2) @(negedge tck);
      op = ops[$urandom_range(0, 8)];
      data = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) n = $urandom_range(0, 40);
      else if (op == 4'h0) n = 32;
      else if (op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6}) n = 8;
      else n = 1;
      scan(op, n, data, got);
      model_scan(op, n, data, exp);
      checks++; if (got !== exp) begin errors++; $display("[TB] FAIL rand_stream op=%h n=%0d got=%h exp=%h", op, n, got, exp); end
      checks++; if (gpio_out !== m_out) begin errors++; $display("[TB] FAIL rand_gpio_out op=%h n=%0d got=%h exp=%h", op, n, gpio_out, m_out); end
      checks++; if (gpio_oe !== m_oe) begin errors++; $display("[TB] FAIL rand_gpio_oe op=%h n=%0d got=%h exp=%h", op, n, gpio_oe, m_oe); end
      checks++; if (length_err !== m_err) begin errors++; $display("[TB] FAIL rand_length_err op=%h n=%0d got=%b exp=%b", op, n, length_err, m_err); end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [159:0] got, exp;
    scan(4'h2, 8, 160'hFF, got);
    model_scan(4'h2, 8, 160'hFF, exp);
    scan(4'h3, 8, 160'h81, got);
    model_scan(4'h3, 8, 160'h81, exp);
    @(negedge tck);
    ir = 4'h3;
    capture_dr = 1'b1;
    @(negedge tck);
    capture_dr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift_dr = 1'b1;
      tdi = 1'b1;
      @(negedge tck);
    end
    tdi = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++; if (gpio_out !== 8'h00 || gpio_oe !== 8'h00) begin errors++; $display("[TB] FAIL midshift_reset got=%h/%h exp=00/00", gpio_out, gpio_oe); end
    checks++; if (tdo !== 1'b0) begin errors++; $display("[TB] FAIL midshift_tdo got=%b exp=0", tdo); end
    shift_dr = 1'b0;
    @(negedge tck);
    reset = 1'b0;
    update_dr = 1'b1;
    @(negedge tck);
    update_dr = 1'b0;
    m_last = 0;
    checks++; if (gpio_out !== 8'h00 || gpio_oe !== 8'h00 || length_err !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_update got=%h/%h/%b exp=00/00/0", gpio_out, gpio_oe, length_err);
    end
    scan(4'h6, 8, 160'h00, got);
    model_scan(4'h6, 8, 160'h00, exp);
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL post_reset_status got=%h exp=%h", got, exp); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idcode();
    test_gpio_write();
    test_set_clr();
    test_length_err();
    test_gpio_in();
    test_saturation();
    test_random();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
